// File: rtl/agg_pkg.sv
// Shared helpers for aggregator_flex: group-length clamping, slot masks and
// widths of the optional statistics counters.
package agg_pkg;

  localparam int unsigned StatGroupsW  = 32;
  localparam int unsigned StatPartialW = 16;
  localparam int unsigned MaskMaxW     = 64;

  // A count of 0 or anything above the packing width means "full width".
  function automatic int unsigned clamp_count(input int unsigned count,
                                              input int unsigned max_count);
    if (count == 0 || count > max_count) return max_count;
    return count;
  endfunction

  // Low 'count' bits set; callers truncate to their slot count.
  function automatic logic [MaskMaxW-1:0] mask_from_count(input int unsigned count);
    if (count >= MaskMaxW) return '1;
    return (MaskMaxW'(1) << count) - MaskMaxW'(1);
  endfunction

endpackage

// File: rtl/agg_out_reg.sv
// Output stage of aggregator_flex: one packed word plus slot mask, loaded from
// the assembly stage and drained whenever the receiver can accept it.
module agg_out_reg
  import agg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FETCH_WIDTH = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_load,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] i_data,
  input  logic [FETCH_WIDTH-1:0]            i_mask,
  input  logic                              i_full_n,
  output logic [FETCH_WIDTH*DATA_WIDTH-1:0] o_data,
  output logic [FETCH_WIDTH-1:0]            o_mask,
  output logic                              o_valid,
  output logic                              o_enq,
  output logic                              o_free
);

  logic [FETCH_WIDTH*DATA_WIDTH-1:0] r_data;
  logic [FETCH_WIDTH-1:0]            r_mask;
  logic                              r_valid;
  logic                              w_enq;

  assign w_enq   = r_valid & i_full_n;
  // Free this cycle if empty or being drained, so a new load can land back to back.
  assign o_free  = ~r_valid | w_enq;
  assign o_enq   = w_enq;
  assign o_data  = r_data;
  assign o_mask  = r_mask;
  assign o_valid = r_valid;

  // Load takes priority over drain; a drained-but-not-reloaded slot reads as zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data  <= '0;
      r_mask  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_mask  <= i_mask;
      r_valid <= 1'b1;
    end else if (w_enq) begin
      r_data  <= '0;
      r_mask  <= '0;
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/aggregator_flex.sv
// aggregator_flex: packs 1..FETCH_WIDTH sender words into one wide receiver
// word, with flush of partial groups and a double-buffered output.
// Optional build macro AGG_STATS_EN adds saturating stat_groups/stat_partial.
module aggregator_flex
  import agg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FETCH_WIDTH = 4,
  parameter int unsigned CNT_W       = $clog2(FETCH_WIDTH + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CNT_W-1:0]                  cfg_count,
  input  logic                              flush,
  input  logic [DATA_WIDTH-1:0]             sender_data,
  input  logic                              sender_empty_n,
  output logic                              sender_deq,
  output logic [FETCH_WIDTH*DATA_WIDTH-1:0] receiver_data,
  output logic [FETCH_WIDTH-1:0]            receiver_mask,
  input  logic                              receiver_full_n,
  output logic                              receiver_enq,
  output logic                              busy
`ifdef AGG_STATS_EN
  ,
  output logic [StatGroupsW-1:0]            stat_groups,
  output logic [StatPartialW-1:0]           stat_partial
`endif
);

  localparam int unsigned WordW = FETCH_WIDTH * DATA_WIDTH;

  logic [WordW-1:0]       r_asm_data, w_asm_data_d;
  logic [CNT_W-1:0]       r_asm_cnt, w_asm_cnt_d;
  logic [CNT_W-1:0]       r_grp_len, w_grp_len_d;
  logic                   r_flush_pend, w_flush_pend_d;

  logic                   w_asm_done;
  logic                   w_asm_has;
  logic                   w_xfer;
  logic                   w_deq;
  logic [CNT_W-1:0]       w_slot;
  logic [CNT_W-1:0]       w_cfg_len;
  logic [FETCH_WIDTH-1:0] w_xfer_mask;
  logic                   w_out_free;
  logic                   w_out_enq;
  logic                   w_out_valid;

  assign w_asm_done  = (r_asm_cnt == r_grp_len);
  assign w_asm_has   = (r_asm_cnt != '0);
  assign w_xfer      = w_out_free & (w_asm_done | (r_flush_pend & w_asm_has));
  // A completed group leaving this cycle frees the assembly register, so the next
  // group's first word is taken in the same cycle: one sender word per cycle.
  assign w_deq       = ~rst & sender_empty_n & ~r_flush_pend & (~w_asm_done | w_xfer);
  assign w_slot      = w_xfer ? '0 : r_asm_cnt;
  assign w_cfg_len   = CNT_W'(clamp_count(32'(cfg_count), FETCH_WIDTH));
  assign w_xfer_mask = FETCH_WIDTH'(mask_from_count(32'(r_asm_cnt)));

  // Assembly next-state: clear on transfer, then place a dequeued word.
  always_comb begin
    w_asm_data_d   = r_asm_data;
    w_asm_cnt_d    = r_asm_cnt;
    w_grp_len_d    = r_grp_len;
    w_flush_pend_d = r_flush_pend;
    if (w_xfer) begin
      w_asm_data_d   = '0;
      w_asm_cnt_d    = '0;
      w_flush_pend_d = 1'b0;
    end
    if (w_deq) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (w_slot == CNT_W'(i)) w_asm_data_d[i*DATA_WIDTH +: DATA_WIDTH] = sender_data;
      end
      w_asm_cnt_d = w_slot + CNT_W'(1);
      // Group length is latched only on the first word of a group.
      if (w_slot == '0) w_grp_len_d = w_cfg_len;
    end
    // A flush on a group that is leaving this cycle is already satisfied.
    if (flush && (w_deq || (w_asm_has && !w_xfer))) w_flush_pend_d = 1'b1;
  end

  // Assembly state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_asm_data   <= '0;
      r_asm_cnt    <= '0;
      r_grp_len    <= CNT_W'(FETCH_WIDTH);
      r_flush_pend <= 1'b0;
    end else begin
      r_asm_data   <= w_asm_data_d;
      r_asm_cnt    <= w_asm_cnt_d;
      r_grp_len    <= w_grp_len_d;
      r_flush_pend <= w_flush_pend_d;
    end
  end

  agg_out_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .FETCH_WIDTH(FETCH_WIDTH)
  ) u_out_reg (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_load  (w_xfer),
    .i_data  (r_asm_data),
    .i_mask  (w_xfer_mask),
    .i_full_n(receiver_full_n),
    .o_data  (receiver_data),
    .o_mask  (receiver_mask),
    .o_valid (w_out_valid),
    .o_enq   (w_out_enq),
    .o_free  (w_out_free)
  );

  assign sender_deq   = w_deq;
  assign receiver_enq = w_out_enq;
  assign busy         = w_out_valid | w_asm_has;

`ifdef AGG_STATS_EN
  logic                    r_out_partial;
  logic [StatGroupsW-1:0]  r_stat_groups;
  logic [StatPartialW-1:0] r_stat_partial;

  // Partial-ness is judged against the group length at transfer time and travels
  // with the word, since grp_len may already belong to the next group at enqueue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_partial  <= 1'b0;
      r_stat_groups  <= '0;
      r_stat_partial <= '0;
    end else begin
      if (w_xfer) r_out_partial <= (r_asm_cnt != r_grp_len);
      if (w_out_enq && (r_stat_groups != '1)) r_stat_groups <= r_stat_groups + StatGroupsW'(1);
      if (w_out_enq && r_out_partial && (r_stat_partial != '1)) begin
        r_stat_partial <= r_stat_partial + StatPartialW'(1);
      end
    end
  end

  assign stat_groups  = r_stat_groups;
  assign stat_partial = r_stat_partial;
`endif

endmodule

// File: doc/aggregator_flex.md
Name: aggregator_flex

Overview:
Parametrised successor to the fixed-ratio aggregator. Dequeues DATA_WIDTH words from a sender FIFO and packs a runtime-selectable number of them (1..FETCH_WIDTH) into one wide receiver word. Adds a flush path for partial groups with a per-slot valid mask, and a double-buffered output for one word per cycle sustained. Sits between a SyncFIFO read side and a wide consumer (e.g. patch or row buffer).

Parameters:
DATA_WIDTH, 8, width of one sender word
FETCH_WIDTH, 4, max words per packed output (>=1)
CNT_W, $clog2(FETCH_WIDTH+1), derived width of count fields; do not override

Ports:
clk  in  1  single clock
rst  in  1  reset; asynchronous, active-high
cfg_count  in  CNT_W  words per group; sampled on first word of each group
flush  in  1  pulse; emit current partial group
sender_data  in  DATA_WIDTH  FIFO read data
sender_empty_n  in  1  FIFO has data
sender_deq  out  1  FIFO dequeue strobe
receiver_data  out  FETCH_WIDTH*DATA_WIDTH  packed word; slot i = bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
receiver_mask  out  FETCH_WIDTH  per-slot valid bits
receiver_full_n  in  1  receiver can accept
receiver_enq  out  1  receiver enqueue strobe
busy  out  1  assembly or output register non-empty

Behaviour:
- Reset (async assert, sync release): asm_cnt=0, asm_data=0, out_valid=0, receiver_data=0, receiver_mask=0, grp_len=FETCH_WIDTH. All outputs 0.
- Two stages: assembly register (asm_data, asm_cnt, grp_len) and output register (receiver_data, receiver_mask, out_valid).
- receiver_enq = out_valid & receiver_full_n (combinational); output register drains on receiver_enq.
- out_free = !out_valid | receiver_enq.
- asm_done = asm_cnt == grp_len. sender_deq = sender_empty_n & !asm_done; combinational.
- On sender_deq: asm_data slot asm_cnt <= sender_data; asm_cnt+1. If asm_cnt==0, grp_len <= clamp(cfg_count): 0 or >FETCH_WIDTH -> FETCH_WIDTH.
- Transfer assembly->output when out_free and (asm_done, or flush_pend with asm_cnt>0): output <= asm_data, mask = (1<<asm_cnt)-1; asm cleared (data to 0, cnt 0) same cycle. Unused slots always 0.
- Latency: last word dequeued in cycle N -> asm_done in N+1 -> receiver_data valid (receiver_enq if full_n) in N+1... precisely: transfer at edge ending N+1, receiver_enq earliest cycle N+2. Sustained throughput 1 sender word/cycle when receiver_full_n=1.
- Flush: flush with asm_cnt==0 and no word dequeued that cycle: ignored. Otherwise sets flush_pend; word dequeued in same cycle as flush is included in the partial group. flush_pend cleared on transfer. While flush_pend, sender_deq held 0. Flush when group already complete: no extra output.
- Backpressure: receiver_full_n=0 holds output; assembly continues filling, then stalls (sender_deq=0) when asm_done.
- cfg_count changes mid-group have no effect until next group.
- busy = out_valid | (asm_cnt!=0).
- Reset mid-group discards partial data; no output produced.

Optional Feature:
AGG_STATS_EN: when defined, adds outputs stat_groups (32b, increments per receiver_enq) and stat_partial (16b, increments per receiver_enq whose mask != full grp_len mask); both saturate, clear on rst. Without it, ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package agg_pkg: function clamp_count, function mask_from_count, localparam for stat widths.
- One sub-module agg_out_reg (output register with valid/ready drain), instantiated once; assembly logic stays in top.

Test Plan:
- DATA_WIDTH=8, FETCH_WIDTH=4, cfg_count=4, FIFO streams 0,1,2,… with receiver_full_n=1 -> receiver_data 0x03020100, 0x07060504, mask 4'hF, one enq per 4 cycles steady state.
- cfg_count=2 then changed to 3 mid-group -> first group {1,0} mask 4'h3, next group 3 words mask 4'h7.
- cfg_count=0 and cfg_count=7 -> both behave as 4.
- 3 words (0x10,0x11,0x12) then flush -> receiver_data 0x00121110, mask 4'h7; flush with empty assembly -> no enq.
- receiver_full_n=0 for 20 cycles with random sender_empty_n -> receiver_enq=0, sender_deq drops after 8 words taken; on release, data continuous, no loss or duplication.
- Assert rst with asm_cnt=2 -> all outputs 0 immediately; next group starts at slot 0. With AGG_STATS_EN: 5 full + 1 flushed group -> stat_groups=6, stat_partial=1.
